// File: rtl/fwd_scheduler.sv
// Forwarding scheduler: arbitrates ingress ports for MAC lookups, tracks outstanding lookups
// in a tag FIFO and round-robin starts frames whose exit queues all have room.
module fwd_scheduler #(
  parameter int unsigned NUM_PORTS = 15,
  parameter int unsigned VLAN_BITS = 12,
  parameter int unsigned LEN_BITS  = 11,
  parameter int unsigned TAG_DEPTH = 8,
  localparam int unsigned PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                           clk_ram_ctl,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS*48-1:0]        in_src_mac,
  input  logic [NUM_PORTS*48-1:0]        in_dst_mac,
  input  logic [NUM_PORTS*VLAN_BITS-1:0] in_vlan,
  input  logic [NUM_PORTS*LEN_BITS-1:0]  in_bytelen,
  output logic                           lookup_en,
  output logic [PORT_BITS-1:0]           lookup_src_port,
  output logic [VLAN_BITS-1:0]           lookup_vlan,
  output logic [47:0]                    lookup_src_mac,
  output logic [47:0]                    lookup_dst_mac,
  input  logic                           lookup_done,
  input  logic                           lookup_hit,
  input  logic [PORT_BITS-1:0]           lookup_dst_port,
  input  logic [NUM_PORTS*VLAN_BITS-1:0] port_vlan,
  input  logic [NUM_PORTS-1:0]           port_trunk,
  input  logic [NUM_PORTS*VLAN_BITS-1:0] trunk_vlan_min,
  input  logic [NUM_PORTS*VLAN_BITS-1:0] trunk_vlan_max,
  input  logic [NUM_PORTS-1:0]           port_space_avail,
  input  logic                           frame_last,
  output logic [NUM_PORTS-1:0]           forward_en,
  output logic [NUM_PORTS-1:0]           frame_port_wr,
  output logic [LEN_BITS-1:0]            frame_len,
  output logic                           drop_pulse,
  output logic                           lookup_err
);

  localparam int unsigned TAG_BITS = $clog2(TAG_DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPending = 2'd1;
  localparam logic [1:0] StReady   = 2'd2;
  localparam logic [1:0] StFwd     = 2'd3;

  logic [1:0]           state_q [NUM_PORTS];
  logic [PORT_BITS-1:0] dst_q   [NUM_PORTS];
  logic [VLAN_BITS-1:0] vlan_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] bcast_q;

  logic [PORT_BITS-1:0] tag_mem_q [TAG_DEPTH];
  logic [TAG_BITS-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TAG_BITS:0]    count_q;

  logic [PORT_BITS-1:0] lookup_rr_q, fwd_rr_q, cur_port_q;
  logic                 active_q;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [PORT_BITS:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PORT_BITS-1:0] ptr);
    int unsigned idx;
    rr_pick = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!rr_pick[PORT_BITS] && req[idx]) rr_pick = {1'b1, PORT_BITS'(idx)};
    end
  endfunction

  function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
    next_port = (32'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  logic [NUM_PORTS-1:0]                cand, elig;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] mask;
  logic [PORT_BITS:0]                  issue_pick, sel_pick;
  logic [PORT_BITS-1:0]                issue_port, sel_port, head;
  logic                                issue_go, pop_go, sel_go, end_go;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      cand[p] = (state_q[p] == StIdle) && in_ready[p];
      mask[p] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (i != p) begin
          if (bcast_q[p]) begin
            mask[p][i] = port_trunk[i]
                ? ((trunk_vlan_min[i*VLAN_BITS +: VLAN_BITS] <= vlan_q[p]) &&
                   (vlan_q[p] <= trunk_vlan_max[i*VLAN_BITS +: VLAN_BITS]))
                : (port_vlan[i*VLAN_BITS +: VLAN_BITS] == vlan_q[p]);
          end else begin
            // Out-of-range destinations never match any bit, so they yield an empty mask.
            mask[p][i] = (32'(dst_q[p]) == i);
          end
        end
      end
      elig[p] = (state_q[p] == StReady) && ((mask[p] & ~port_space_avail) == '0);
    end
  end

  assign issue_pick = rr_pick(cand, lookup_rr_q);
  assign issue_port = issue_pick[PORT_BITS-1:0];
  assign issue_go   = issue_pick[PORT_BITS] && (32'(count_q) != TAG_DEPTH);
  assign pop_go     = lookup_done && (count_q != '0);
  assign head       = tag_mem_q[rd_ptr_q];

  assign sel_pick = rr_pick(elig, fwd_rr_q);
  assign sel_port = sel_pick[PORT_BITS-1:0];
  assign sel_go   = sel_pick[PORT_BITS] && (!active_q || frame_last);
  assign end_go   = active_q && frame_last;

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= StIdle;
        dst_q[p]   <= '0;
        vlan_q[p]  <= '0;
      end
      for (int unsigned t = 0; t < TAG_DEPTH; t++) tag_mem_q[t] <= '0;
      bcast_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      lookup_rr_q     <= '0;
      fwd_rr_q        <= '0;
      cur_port_q      <= '0;
      active_q        <= 1'b0;
      lookup_en       <= 1'b0;
      lookup_src_port <= '0;
      lookup_vlan     <= '0;
      lookup_src_mac  <= '0;
      lookup_dst_mac  <= '0;
      forward_en      <= '0;
      frame_port_wr   <= '0;
      frame_len       <= '0;
      drop_pulse      <= 1'b0;
      lookup_err      <= 1'b0;
    end else begin
      lookup_en <= issue_go;
      if (issue_go) begin
        lookup_src_port       <= issue_port;
        lookup_vlan           <= in_vlan[32'(issue_port)*VLAN_BITS +: VLAN_BITS];
        lookup_src_mac        <= in_src_mac[32'(issue_port)*48 +: 48];
        lookup_dst_mac        <= in_dst_mac[32'(issue_port)*48 +: 48];
        tag_mem_q[wr_ptr_q]   <= issue_port;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
        state_q[issue_port]   <= StPending;
        lookup_rr_q           <= next_port(issue_port);
      end

      if (pop_go) begin
        dst_q[head]   <= lookup_dst_port;
        bcast_q[head] <= ~lookup_hit;
        vlan_q[head]  <= in_vlan[32'(head)*VLAN_BITS +: VLAN_BITS];
        state_q[head] <= StReady;
        rd_ptr_q      <= rd_ptr_q + 1'b1;
      end
      if (lookup_done && (count_q == '0)) lookup_err <= 1'b1;

      case ({issue_go, pop_go})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      frame_port_wr <= '0;
      drop_pulse    <= 1'b0;
      if (end_go) begin
        state_q[cur_port_q] <= StIdle;
        forward_en          <= '0;
        active_q            <= 1'b0;
      end
      // Selection overrides the clear above so a back-to-back handoff has no idle cycle.
      if (sel_go) begin
        state_q[sel_port] <= StFwd;
        fwd_rr_q          <= next_port(sel_port);
        cur_port_q        <= sel_port;
        active_q          <= 1'b1;
        forward_en        <= NUM_PORTS'(1) << sel_port;
        frame_port_wr     <= mask[sel_port];
        frame_len         <= in_bytelen[32'(sel_port)*LEN_BITS +: LEN_BITS];
        drop_pulse        <= (mask[sel_port] == '0);
      end
    end
  end

endmodule

// File: tb/tb_fwd_scheduler.sv
// Directed bench for fwd_scheduler: unicast, broadcast filter, backpressure/RR, drop,
// tag FIFO limits and reset mid-frame.
module tb_fwd_scheduler;
  localparam int NP = 15;
  localparam int VB = 12;
  localparam int LB = 11;
  localparam int PB = 4;

  logic              clk_ram_ctl = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_ready;
  logic [NP*48-1:0]  in_src_mac, in_dst_mac;
  logic [NP*VB-1:0]  in_vlan;
  logic [NP*LB-1:0]  in_bytelen;
  logic              lookup_en;
  logic [PB-1:0]     lookup_src_port;
  logic [VB-1:0]     lookup_vlan;
  logic [47:0]       lookup_src_mac, lookup_dst_mac;
  logic              lookup_done, lookup_hit;
  logic [PB-1:0]     lookup_dst_port;
  logic [NP*VB-1:0]  port_vlan, trunk_vlan_min, trunk_vlan_max;
  logic [NP-1:0]     port_trunk, port_space_avail;
  logic              frame_last;
  logic [NP-1:0]     forward_en, frame_port_wr;
  logic [LB-1:0]     frame_len;
  logic              drop_pulse, lookup_err;

  int total = 0;
  int bad   = 0;
  int n_issue;

  fwd_scheduler dut (
    .clk_ram_ctl      (clk_ram_ctl),
    .rst              (rst),
    .in_ready         (in_ready),
    .in_src_mac       (in_src_mac),
    .in_dst_mac       (in_dst_mac),
    .in_vlan          (in_vlan),
    .in_bytelen       (in_bytelen),
    .lookup_en        (lookup_en),
    .lookup_src_port  (lookup_src_port),
    .lookup_vlan      (lookup_vlan),
    .lookup_src_mac   (lookup_src_mac),
    .lookup_dst_mac   (lookup_dst_mac),
    .lookup_done      (lookup_done),
    .lookup_hit       (lookup_hit),
    .lookup_dst_port  (lookup_dst_port),
    .port_vlan        (port_vlan),
    .port_trunk       (port_trunk),
    .trunk_vlan_min   (trunk_vlan_min),
    .trunk_vlan_max   (trunk_vlan_max),
    .port_space_avail (port_space_avail),
    .frame_last       (frame_last),
    .forward_en       (forward_en),
    .frame_port_wr    (frame_port_wr),
    .frame_len        (frame_len),
    .drop_pulse       (drop_pulse),
    .lookup_err       (lookup_err)
  );

  always #5 clk_ram_ctl = ~clk_ram_ctl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_ram_ctl);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lookup_en"}, 64'(lookup_en), 64'd0);
    check({tag, "_fwd_en"}, 64'(forward_en), 64'd0);
    check({tag, "_port_wr"}, 64'(frame_port_wr), 64'd0);
    check({tag, "_len"}, 64'(frame_len), 64'd0);
    check({tag, "_drop"}, 64'(drop_pulse), 64'd0);
    check({tag, "_err"}, 64'(lookup_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_ready = '0;
    lookup_done = 1'b0;
    lookup_hit = 1'b0;
    lookup_dst_port = '0;
    frame_last = 1'b0;
    port_trunk = '0;
    port_space_avail = '1;
    port_vlan = '0;
    trunk_vlan_min = '0;
    trunk_vlan_max = '0;
    for (int p = 0; p < NP; p++) begin
      in_src_mac[p*48 +: 48] = 48'h0A00_0000_0000 + 48'(p);
      in_dst_mac[p*48 +: 48] = 48'hB000_0000_0000 + 48'(p);
      in_vlan[p*VB +: VB]    = VB'(p + 1);
      in_bytelen[p*LB +: LB] = LB'(64 + p);
    end
    in_bytelen[2*LB +: LB] = 11'd100;
    in_vlan[2*VB +: VB]    = 12'd5;

    tick(2);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Unicast port 2 -> 7
    in_ready = 15'h0004;
    tick();
    check("uc_lookup_en", 64'(lookup_en), 64'd1);
    check("uc_src_port", 64'(lookup_src_port), 64'd2);
    check("uc_vlan", 64'(lookup_vlan), 64'd5);
    check("uc_src_mac", 64'(lookup_src_mac), 64'h0A00_0000_0002);
    check("uc_dst_mac", 64'(lookup_dst_mac), 64'hB000_0000_0002);
    in_ready = '0;
    lookup_done = 1'b1; lookup_hit = 1'b1; lookup_dst_port = 4'd7;
    tick();
    check("uc_lookup_pulse", 64'(lookup_en), 64'd0);
    lookup_done = 1'b0;
    tick();
    check("uc_fwd_en", 64'(forward_en), 64'h0004);
    check("uc_port_wr", 64'(frame_port_wr), 64'h0080);
    check("uc_len", 64'(frame_len), 64'd100);
    check("uc_drop", 64'(drop_pulse), 64'd0);
    tick();
    check("uc_port_wr_pulse", 64'(frame_port_wr), 64'd0);
    check("uc_fwd_hold", 64'(forward_en), 64'h0004);
    frame_last = 1'b1;
    tick();
    check("uc_fwd_clear", 64'(forward_en), 64'd0);
    frame_last = 1'b0;

    // Broadcast from port 0 on VLAN 10
    in_vlan[0*VB +: VB] = 12'd10;
    port_vlan[1*VB +: VB] = 12'd10;
    port_vlan[3*VB +: VB] = 12'd20;
    port_trunk = 15'h0030;
    trunk_vlan_min[4*VB +: VB] = 12'd1;   trunk_vlan_max[4*VB +: VB] = 12'd100;
    trunk_vlan_min[5*VB +: VB] = 12'd200; trunk_vlan_max[5*VB +: VB] = 12'd300;
    in_ready = 15'h0001;
    tick();
    check("bc_src_port", 64'(lookup_src_port), 64'd0);
    check("bc_vlan", 64'(lookup_vlan), 64'd10);
    in_ready = '0;
    lookup_done = 1'b1; lookup_hit = 1'b0;
    tick();
    lookup_done = 1'b0;
    tick();
    check("bc_fwd_en", 64'(forward_en), 64'h0001);
    check("bc_port_wr", 64'(frame_port_wr), 64'h0012);
    check("bc_len", 64'(frame_len), 64'd64);
    frame_last = 1'b1;
    tick();
    check("bc_fwd_clear", 64'(forward_en), 64'd0);
    frame_last = 1'b0;

    // Backpressure then back-to-back RR: ports 1 and 3 unicast to 6
    port_space_avail = 15'h7FBF;
    in_ready = 15'h000A;
    tick();
    check("bp_issue1", 64'(lookup_src_port), 64'd1);
    tick();
    check("bp_issue3", 64'(lookup_src_port), 64'd3);
    in_ready = '0;
    lookup_done = 1'b1; lookup_hit = 1'b1; lookup_dst_port = 4'd6;
    tick(2);
    lookup_done = 1'b0;
    tick(3);
    check("bp_blocked", 64'(forward_en), 64'd0);
    port_space_avail = '1;
    tick();
    check("bp_first", 64'(forward_en), 64'h0002);
    check("bp_first_wr", 64'(frame_port_wr), 64'h0040);
    frame_last = 1'b1;
    tick();
    check("bp_handoff", 64'(forward_en), 64'h0008);
    check("bp_second_wr", 64'(frame_port_wr), 64'h0040);
    frame_last = 1'b0;
    tick();
    check("bp_second_hold", 64'(forward_en), 64'h0008);
    frame_last = 1'b1;
    tick();
    check("bp_second_clear", 64'(forward_en), 64'd0);
    frame_last = 1'b0;

    // Drop: port 4 unicast to itself
    in_ready = 15'h0010;
    tick();
    check("drop_issue", 64'(lookup_src_port), 64'd4);
    in_ready = '0;
    lookup_done = 1'b1; lookup_hit = 1'b1; lookup_dst_port = 4'd4;
    tick();
    lookup_done = 1'b0;
    tick();
    check("drop_fwd_en", 64'(forward_en), 64'h0010);
    check("drop_port_wr", 64'(frame_port_wr), 64'd0);
    check("drop_pulse", 64'(drop_pulse), 64'd1);
    tick();
    check("drop_pulse_end", 64'(drop_pulse), 64'd0);
    frame_last = 1'b1;
    tick();
    check("drop_fwd_clear", 64'(forward_en), 64'd0);
    frame_last = 1'b0;
    in_ready = 15'h0010;
    tick();
    check("drop_reissue_en", 64'(lookup_en), 64'd1);
    check("drop_reissue_port", 64'(lookup_src_port), 64'd4);
    in_ready = '0;

    // Tag FIFO depth limit
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_ready = 15'h01FF;
    n_issue = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (lookup_en) begin
        check("fifo_issue_order", 64'(lookup_src_port), 64'(n_issue));
        n_issue++;
      end
    end
    check("fifo_issue_count", 64'(n_issue), 64'd8);
    lookup_done = 1'b1; lookup_hit = 1'b1; lookup_dst_port = 4'd9;
    tick();
    check("fifo_full_pop_no_push", 64'(lookup_en), 64'd0);
    lookup_done = 1'b0;
    tick();
    check("fifo_ninth_en", 64'(lookup_en), 64'd1);
    check("fifo_ninth_port", 64'(lookup_src_port), 64'd8);
    lookup_done = 1'b1;
    tick(8);
    check("fifo_err_before", 64'(lookup_err), 64'd0);
    tick();
    check("fifo_err_set", 64'(lookup_err), 64'd1);
    lookup_done = 1'b0;
    tick(2);
    check("fifo_err_sticky", 64'(lookup_err), 64'd1);

    // Reset while port 0 is forwarding
    check("rst_pre_fwd", 64'(forward_en), 64'h0001);
    rst = 1'b1;
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    tick();
    check("rst_reissue_en", 64'(lookup_en), 64'd1);
    check("rst_reissue_port", 64'(lookup_src_port), 64'd0);
    in_ready = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scheduler.md
Name: fwd_scheduler

Overview:
- Parametrised next-generation forwarding scheduler between the ingress packet buffers and the exit queues, in the clk_ram_ctl domain.
- Arbitrates ingress ports for MAC-table lookups, tracks outstanding lookups in a tag FIFO, and round-robin selects frames whose destinations all have space.
- Computes per-frame exit masks with a trunk VLAN range filter, and drains frames that have no valid destination.

Parameters:
- NUM_PORTS, 15, number of ingress/egress ports; PORT_BITS = $clog2(NUM_PORTS) is derived.
- VLAN_BITS, 12, VLAN ID width.
- LEN_BITS, 11, frame byte-length width.
- TAG_DEPTH, 8, maximum outstanding lookups (power of 2).

Ports:
- clk_ram_ctl  in  1  datapath clock.
- rst  in  1  synchronous active-high reset.
- in_ready  in  NUM_PORTS  ingress port p holds a parsed frame header awaiting forwarding.
- in_src_mac  in  NUM_PORTS*48  per-port source MAC.
- in_dst_mac  in  NUM_PORTS*48  per-port destination MAC.
- in_vlan  in  NUM_PORTS*VLAN_BITS  per-port frame VLAN.
- in_bytelen  in  NUM_PORTS*LEN_BITS  per-port frame length.
- lookup_en  out  1  single-cycle MAC-table request.
- lookup_src_port  out  PORT_BITS  requesting port.
- lookup_vlan  out  VLAN_BITS  request VLAN.
- lookup_src_mac  out  48  request source MAC.
- lookup_dst_mac  out  48  request destination MAC.
- lookup_done  in  1  result valid; results return in request order.
- lookup_hit  in  1  destination found.
- lookup_dst_port  in  PORT_BITS  destination port on hit.
- port_vlan  in  NUM_PORTS*VLAN_BITS  access VLAN per egress port.
- port_trunk  in  NUM_PORTS  egress port is a trunk.
- trunk_vlan_min  in  NUM_PORTS*VLAN_BITS  lowest VLAN allowed on a trunk (inclusive).
- trunk_vlan_max  in  NUM_PORTS*VLAN_BITS  highest VLAN allowed on a trunk (inclusive).
- port_space_avail  in  NUM_PORTS  exit queue can accept a maximum-size frame.
- frame_last  in  1  final beat of the frame currently being forwarded.
- forward_en  out  NUM_PORTS  one-hot; enables the packet buffer readout of the source port.
- frame_port_wr  out  NUM_PORTS  single-cycle exit-queue write mask.
- frame_len  out  LEN_BITS  length of the frame being started.
- drop_pulse  out  1  frame started with an empty exit mask.
- lookup_err  out  1  sticky flag: lookup_done arrived while the tag FIFO was empty.

Behaviour:
- Reset: every output is 0, all port states are IDLE, both RR pointers are 0, the tag FIFO is empty, and no frame is active.
- Port state machine: IDLE -> PENDING on lookup issue; PENDING -> READY on the matching lookup_done; READY -> FWD on selection; FWD -> IDLE on frame_last.
- Lookup arbitration:
  - At most one issue per cycle, only when the tag FIFO is not full.
  - A push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - Candidates are ports that are IDLE with in_ready set. Scan starts at lookup_rr and wraps from NUM_PORTS-1 to 0; the first candidate wins.
  - lookup_rr <= winner+1, wrapping to 0.
  - The request outputs are registered, so lookup_en asserts 1 cycle after a candidate appears. The winning port index is pushed into the tag FIFO.
- Lookup return:
  - lookup_done pops the FIFO head. That port stores dst_port, bcast = !lookup_hit, and vlan, then goes READY.
  - Pop and push in the same cycle are both honoured.
  - lookup_done with the FIFO empty is ignored and sets lookup_err.
- Exit mask for a READY port p with VLAN v:
  - Unicast: one-hot(dst_port), unless dst_port == p or dst_port >= NUM_PORTS, in which case the mask is 0.
  - Broadcast: bit i (i != p) = (!port_trunk[i] && port_vlan[i] == v) || (port_trunk[i] && trunk_vlan_min[i] <= v <= trunk_vlan_max[i]).
- Eligibility: p is READY and (mask == 0 or (mask & ~port_space_avail) == 0).
- Forward selection:
  - Allowed when no frame is active, or in the cycle frame_last is high (back-to-back).
  - RR scan from fwd_rr; fwd_rr <= winner+1, wrapping to 0.
  - The winner goes to FWD in the selection cycle, so it cannot be reselected.
- Start, 1 cycle after selection:
  - forward_en[winner] rises and is held until frame_last.
  - frame_port_wr pulses the mask latched at selection for 1 cycle.
  - frame_len = in_bytelen[winner].
  - drop_pulse = (mask == 0) for 1 cycle. A dropped frame is still drained via forward_en.
- frame_last:
  - Clears forward_en on the next cycle and returns the source port to IDLE.
  - On a back-to-back handoff, forward_en moves directly from the old one-hot value to the new one with no zero cycle.
  - frame_last with no active frame is ignored.
- Reset mid-frame: all outputs return to 0 the cycle after rst; in-flight lookups are discarded.

Test Plan:
- Unicast: port 2 in_ready, VLAN 5, lookup_done hit, dst 7, all space available -> lookup_en with src 2; forward_en = 0x0004; frame_port_wr = 0x0080 for one cycle; frame_len = in_bytelen[2].
- Broadcast VLAN filter: port 0 miss, VLAN 10; port_vlan[1] = 10, port_vlan[3] = 20, port 4 trunk with range 1..100, port 5 trunk with range 200..300 -> frame_port_wr = 0x0012.
- Backpressure and RR: ports 1 and 3 READY, both unicast to 6, port_space_avail[6] = 0 -> no forward_en. Raise space -> port 1 is served, then port 3 after frame_last, with no gap cycle.
- Drop: unicast with dst == src (port 4) -> forward_en = 0x0010, frame_port_wr = 0, drop_pulse = 1; port 4 returns to IDLE after frame_last.
- Tag FIFO: 9 ports ready with the lookup table stalled -> exactly 8 lookup_en pulses. One lookup_done -> 9th issue the next cycle. Extra lookup_done with the FIFO empty -> lookup_err = 1 until rst.
- Reset mid-frame: rst during forwarding -> all outputs 0 the next cycle; port re-issues its lookup after rst drops.
